// File: rtl/lcd_cmd_engine_if.sv
// Command handshake between the memory-mapped LCD register and the timing engine.
//   cmd_valid : one-cycle store strobe to the LCD register address
//   cmd       : LCD register word ([31]=ON, [9]=RS, [8]=RW, [7:0]=DATA)
//   cmd_ready : engine idle; a strobe in this cycle is accepted
//   busy      : inverse of cmd_ready (status readback)
//   drop_cnt  : saturating count of strobes rejected while busy
interface lcd_cmd_engine_if;
  localparam int unsigned CMD_W  = 32;
  localparam int unsigned DROP_W = 8;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_ready;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (output cmd_valid, cmd, input cmd_ready, busy, drop_cnt);
  modport slave  (input cmd_valid, cmd, output cmd_ready, busy, drop_cnt);
endinterface

// File: rtl/lcd_cmd_engine.sv
// HD44780 command timing engine: turns each accepted LCD register store into
// RS/DATA setup, a timed EN pulse, hold, and the controller execution wait.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   cmd_if        : command handshake (slave side), see lcd_cmd_engine_if
//   lcd_on_o      : panel power/backlight
//   lcd_en_o      : enable strobe, high exactly while in PULSE
//   lcd_rs_o      : register select
//   lcd_rw_o      : read/write, always 0 (write-only engine)
//   lcd_data_o    : 8-bit data bus
module lcd_cmd_engine #(
  parameter int unsigned T_AS        = 2,
  parameter int unsigned T_PW        = 12,
  parameter int unsigned T_H         = 1,
  parameter int unsigned T_WAIT      = 2000,
  parameter int unsigned T_WAIT_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lcd_cmd_engine_if.slave   cmd_if,
  output logic              lcd_on_o,
  output logic              lcd_en_o,
  output logic              lcd_rs_o,
  output logic              lcd_rw_o,
  output logic [7:0]        lcd_data_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DROP_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              long_q;
  logic [DROP_W-1:0] drop_q;
  logic              accept;
  logic              reject;
  logic              unused_cmd_bits;

  assign accept = cmd_if.cmd_valid && (state_q == S_IDLE);
  assign reject = cmd_if.cmd_valid && (state_q != S_IDLE);

  assign cmd_if.cmd_ready = (state_q == S_IDLE);
  assign cmd_if.busy      = (state_q != S_IDLE);
  assign cmd_if.drop_cnt  = drop_q;
  assign lcd_rw_o         = 1'b0;

  // RW and the reserved bits of the register word have no effect.
  assign unused_cmd_bits = ^{cmd_if.cmd[30:10], cmd_if.cmd[8]};

  // State and delay counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each timed phase counts down and reloads for the next on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(T_AS - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_PW - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_H - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = long_q ? CNT_W'(T_WAIT_LONG - 1) : CNT_W'(T_WAIT - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Command fields latch only on acceptance; clear/home (RS=0, DATA<4) get the long wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_rs_o   <= 1'b0;
      lcd_data_o <= '0;
      lcd_on_o   <= 1'b0;
      long_q     <= 1'b0;
    end else if (accept) begin
      lcd_rs_o   <= cmd_if.cmd[9];
      lcd_data_o <= cmd_if.cmd[DATA_W-1:0];
      lcd_on_o   <= cmd_if.cmd[31];
      long_q     <= ~cmd_if.cmd[9] && (cmd_if.cmd[7:2] == 6'd0);
    end
  end

  // Registered EN mirrors the PULSE state one-for-one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_en_o <= 1'b0;
    end else begin
      lcd_en_o <= (state_d == S_PULSE);
    end
  end

  // Saturating count of strobes that arrive while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else if (reject && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Scoreboard bench for lcd_cmd_engine with shortened execution waits.
module tb_lcd_cmd_engine;

  localparam int TAS   = 2;
  localparam int TPW   = 12;
  localparam int TH    = 1;
  localparam int TW    = 40;
  localparam int TWL   = 120;

  logic clk_i;
  logic rst_ni;
  logic lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0] lcd_data_o;

  lcd_cmd_engine_if bus();

  lcd_cmd_engine #(
    .T_AS(TAS), .T_PW(TPW), .T_H(TH), .T_WAIT(TW), .T_WAIT_LONG(TWL), .CNT_W(17)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_if     (bus),
    .lcd_on_o   (lcd_on_o),
    .lcd_en_o   (lcd_en_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_data_o (lcd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Number of rising edges seen so far; edge k is the k-th posedge.
  longint cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One scoreboard entry per strobe, effective from edge k onward.
  typedef struct {
    longint     k;
    bit         acc;
    longint     free;
    int         drops;
    bit         rs;
    logic [7:0] data;
    bit         on;
  } ev_t;

  ev_t ev_q[$];

  // Stimulus-side reference: command acceptance and busy window from the timing rules.
  longint s_free  = 0;
  int     s_drops = 0;

  task automatic drive(input bit v, input logic [31:0] c, output bit acc);
    ev_t    e;
    longint w;
    @(negedge clk_i);
    bus.cmd_valid = v;
    bus.cmd       = c;
    acc = 1'b0;
    if (v && rst_ni) begin
      e.k    = cyc + 1;
      e.rs   = c[9];
      e.data = c[7:0];
      e.on   = c[31];
      if (cyc >= s_free) begin
        w      = (!c[9] && c[7:0] < 8'd4) ? longint'(TWL) : longint'(TW);
        s_free = e.k + TAS + TPW + TH + w;
        e.acc  = 1'b1;
        acc    = 1'b1;
      end else begin
        if (s_drops < 255) s_drops++;
        e.acc = 1'b0;
      end
      e.free  = s_free;
      e.drops = s_drops;
      ev_q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] c);
    bit a;
    drive(1'b1, c, a);
    drive(1'b0, 32'h0, a);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, a);
  endtask

  task automatic wait_idle();
    bit a;
    int n;
    n = 0;
    while (cyc < s_free && n < 2000) begin
      drive(1'b0, 32'h0, a);
      n++;
    end
    if (n >= 2000) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  // Monitor: applies scoreboard entries as their edges pass and checks every output each cycle.
  longint     m_k, m_free;
  int         m_drops;
  bit         m_rs, m_on;
  logic [7:0] m_data;
  bit         en_exp;
  ev_t        me;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      ev_q.delete();
      m_k = -1000; m_free = 0; m_drops = 0;
      m_rs = 0; m_on = 0; m_data = '0;
      chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_busy",  64'(bus.busy),      64'd0);
      chk("rst_en",    64'(lcd_en_o),      64'd0);
      chk("rst_drop",  64'(bus.drop_cnt),  64'd0);
      chk("rst_data",  64'(lcd_data_o),    64'd0);
    end else begin
      while (ev_q.size() > 0 && ev_q[0].k <= cyc) begin
        me = ev_q.pop_front();
        if (me.acc) begin
          m_k = me.k; m_free = me.free;
          m_rs = me.rs; m_data = me.data; m_on = me.on;
        end
        m_drops = me.drops;
      end
      en_exp = (cyc >= m_k + TAS) && (cyc < m_k + TAS + TPW);
      chk("ready", 64'(bus.cmd_ready), 64'(cyc >= m_free));
      chk("busy",  64'(bus.busy),      64'(cyc < m_free));
      chk("en",    64'(lcd_en_o),      64'(en_exp));
      chk("rs",    64'(lcd_rs_o),      64'(m_rs));
      chk("data",  64'(lcd_data_o),    64'(m_data));
      chk("on",    64'(lcd_on_o),      64'(m_on));
      chk("rw",    64'(lcd_rw_o),      64'd0);
      chk("drop",  64'(bus.drop_cnt),  64'(m_drops));
    end
  end

  logic [31:0] rc;
  bit          acc;
  int          n;

  initial begin
    rst_ni = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    s_free = 0; s_drops = 0;

    // Normal write, then clear / long / normal classification.
    send(32'h8000_0241);
    wait_idle();
    send(32'h8000_0001);
    // Three single-cycle strobes while busy are dropped.
    idle(20);
    send(32'h8000_0242); send(32'h8000_0242); send(32'h8000_0242);
    wait_idle();
    send(32'h8000_0000);
    wait_idle();
    send(32'h8000_0004);
    wait_idle();

    // Valid held high: one accept, then back-to-back accept exactly when ready returns.
    drive(1'b1, 32'h8000_0250, acc);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      drive(1'b1, 32'h8000_0251, acc);
      n++;
    end
    chk("b2b_accepted", 64'(acc), 64'd1);

    // Long run of strobes saturates the drop counter.
    for (int i = 0; i < 400; i++) begin
      rc = $urandom;
      rc[9] = 1'b1;
      drive(1'b1, rc, acc);
    end
    idle(1);
    wait_idle();

    // Reset in the middle of the EN pulse.
    send(32'h8000_0233);
    idle(4);
    #2;
    chk("pre_rst_en", 64'(lcd_en_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_en",    64'(lcd_en_o),      64'd0);
    chk("async_data",  64'(lcd_data_o),    64'd0);
    chk("async_on",    64'(lcd_on_o),      64'd0);
    chk("async_ready", 64'(bus.cmd_ready), 64'd1);
    idle(2);
    #2 rst_ni = 1'b1;
    s_free = 0; s_drops = 0;
    send(32'h8000_0248);
    wait_idle();

    // RW bit ignored, ON cleared.
    send(32'h0000_0341);
    wait_idle();

    // Randomised traffic with a mix of long and normal commands.
    for (int i = 0; i < 2500; i++) begin
      rc = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rc[9] = 1'b0;
        rc[7:2] = 6'd0;
      end
      drive($urandom_range(0, 5) == 0, rc, acc);
    end
    idle(1);
    wait_idle();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
